segre_store_buffer: RTL

SEGRE_STORE_BUFFER -- requirements
Module: segre_store_buffer

---
 rtl/segre_store_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/segre_store_buffer.sv
// Store buffer: circular FIFO of pending stores that drains in order to
// memory and forwards data to younger loads that hit a buffered store.
module segre_store_buffer #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [ADDR_W-1:0]                  push_addr_i,
  input  logic [DATA_W-1:0]                  push_data_i,
  input  logic [1:0]                         push_type_i,
  input  logic                               ld_valid_i,
  input  logic [ADDR_W-1:0]                  ld_addr_i,
  input  logic [1:0]                         ld_type_i,
  output logic                               fwd_hit_o,
  output logic                               fwd_conflict_o,
  output logic [DATA_W-1:0]                  fwd_data_o,
  output logic                               drain_valid_o,
  input  logic                               drain_ready_i,
  output logic [ADDR_W-1:0]                  drain_addr_o,
  output logic [DATA_W-1:0]                  drain_data_o,
  output logic [3:0]                         drain_be_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_ENTRIES);

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] typ, input logic [1:0] off);
    logic [3:0] m;
    case (typ)
      BYTE:    m = 4'b0001 << off;
      HALF:    m = 4'b0011 << off;
      WORD:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Widen a byte mask to a per-bit mask over the data word.
  function automatic logic [DATA_W-1:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [ADDR_W-3:0] word_addr_r [NUM_ENTRIES];
  logic [1:0]        off_r       [NUM_ENTRIES];
  logic [3:0]        mask_r      [NUM_ENTRIES];
  logic [DATA_W-1:0] data_r      [NUM_ENTRIES];

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic             push_fire_s;
  logic             drain_fire_s;
  logic [3:0]       ld_mask_s;
  logic             found_s;
  logic [PTR_W-1:0] sel_s;
  logic [PTR_W-1:0] scan_idx_s;
  logic [3:0]       sel_cover_s;
  logic             unused_off_s;

  // Status is a pure function of the registered occupancy.
  assign full_o        = (count_r == CNT_MAX);
  assign empty_o       = (count_r == {CNT_W{1'b0}});
  assign count_o       = count_r;
  assign push_ready_o  = !full_o;
  assign drain_valid_o = !empty_o;
  assign push_fire_s   = push_valid_i && push_ready_o;
  assign drain_fire_s  = drain_valid_o && drain_ready_i;

  assign drain_addr_o  = {word_addr_r[head_r], 2'b00};
  assign drain_data_o  = data_r[head_r];
  assign drain_be_o    = mask_r[head_r];
  assign ld_mask_s     = byte_mask(ld_type_i, ld_addr_i[1:0]);

  // Pointer and occupancy bookkeeping; reset wins over any push or drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (drain_fire_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_fire_s, drain_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until covered by count_r.
  always_ff @(posedge clk_i) begin
    if (push_fire_s && !rst_i) begin
      word_addr_r[tail_r] <= push_addr_i[ADDR_W-1:2];
      off_r[tail_r]       <= push_addr_i[1:0];
      mask_r[tail_r]      <= byte_mask(push_type_i, push_addr_i[1:0]);
      data_r[tail_r]      <= push_data_i << {push_addr_i[1:0], 3'b000};
    end
  end

  // Scan oldest to youngest so the last overlapping entry found is the youngest.
  always_comb begin
    found_s    = 1'b0;
    sel_s      = head_r;
    scan_idx_s = head_r;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      scan_idx_s = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) &&
          (word_addr_r[scan_idx_s] == ld_addr_i[ADDR_W-1:2]) &&
          ((mask_r[scan_idx_s] & ld_mask_s) != 4'b0000)) begin
        found_s = 1'b1;
        sel_s   = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Full coverage forwards the selected lanes; partial coverage stalls the load.
  always_comb begin
    fwd_hit_o      = 1'b0;
    fwd_conflict_o = 1'b0;
    fwd_data_o     = {DATA_W{1'b0}};
    sel_cover_s    = mask_r[sel_s] & ld_mask_s;
    if (ld_valid_i && found_s) begin
      if (sel_cover_s == ld_mask_s) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_r[sel_s] & lane_bits(ld_mask_s);
      end else begin
        fwd_conflict_o = 1'b1;
      end
    end else begin
      fwd_hit_o = 1'b0;
    end
  end

  // The byte offset is already encoded in the mask; it is kept for debug visibility only.
  always_comb begin
    unused_off_s = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      unused_off_s = unused_off_s ^ (^off_r[i]);
    end
  end

endmodule
